// File: rtl/vid_htiming.sv
// ---------------------------------------------------------------------------
// vid_htiming -- horizontal video timing generator
//
// A W-bit pixel-clock counter runs from 0 to the shadowed line period and
// wraps. Every compare is a full W-bit equality (wide AND of per-bit XNOR
// terms) against shadow copies of the programmed values. All outputs are
// registered and therefore lag the matching count by one clock.
//
// Ports
//   clk        in   video pixel clock
//   resetl     in   asynchronous active-low reset
//   vid_en     in   video timing enable
//   hperiod    in   W  last count of a line (line length = hperiod+1)
//   hbb        in   W  blank begin count
//   hbe        in   W  blank end count
//   hss        in   W  sync start count
//   hse        in   W  sync end count
//   hcnt       out  W  current horizontal count
//   hsync      out  horizontal sync, active high
//   hblank     out  horizontal blank, active high
//   line_end   out  one-cycle pulse, first cycle of a new line
//   half_line  out  one-cycle pulse after the mid-line count
// ---------------------------------------------------------------------------
module vid_htiming #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         resetl,
  input  logic         vid_en,
  input  logic [W-1:0] hperiod,
  input  logic [W-1:0] hbb,
  input  logic [W-1:0] hbe,
  input  logic [W-1:0] hss,
  input  logic [W-1:0] hse,
  output logic [W-1:0] hcnt,
  output logic         hsync,
  output logic         hblank,
  output logic         line_end,
  output logic         half_line
);

  // Compare slots
  localparam int C_PERIOD = 0;
  localparam int C_HALF   = 1;
  localparam int C_BB     = 2;
  localparam int C_BE     = 3;
  localparam int C_SS     = 4;
  localparam int C_SE     = 5;
  localparam int NCMP     = 6;

  logic [W-1:0] hcnt_q, hcnt_d;
  logic         hsync_q, hsync_d;
  logic         hblank_q, hblank_d;
  logic         line_end_q, line_end_d;
  logic         half_line_q, half_line_d;
  logic         en_d_q;
  logic [W-1:0] sh_period_q, sh_period_d;
  logic [W-1:0] sh_bb_q, sh_bb_d;
  logic [W-1:0] sh_be_q, sh_be_d;
  logic [W-1:0] sh_ss_q, sh_ss_d;
  logic [W-1:0] sh_se_q, sh_se_d;

  logic         first_cyc;
  logic [W-1:0] op_period, op_bb, op_be, op_ss, op_se;
  logic [W-1:0] cmp_val [NCMP];
  logic [NCMP-1:0] match;

  assign first_cyc = vid_en & ~en_d_q;

  // On the first enabled cycle the shadows are being loaded on this very
  // edge, so the compares look at the incoming values instead of whatever
  // stale contents the shadows hold. Otherwise line 0 could see spurious
  // matches at count 0 (e.g. a half_line pulse from shadows still at 0).
  assign op_period = first_cyc ? hperiod : sh_period_q;
  assign op_bb     = first_cyc ? hbb     : sh_bb_q;
  assign op_be     = first_cyc ? hbe     : sh_be_q;
  assign op_ss     = first_cyc ? hss     : sh_ss_q;
  assign op_se     = first_cyc ? hse     : sh_se_q;

  assign cmp_val[C_PERIOD] = op_period;
  assign cmp_val[C_HALF]   = op_period >> 1;
  assign cmp_val[C_BB]     = op_bb;
  assign cmp_val[C_BE]     = op_be;
  assign cmp_val[C_SS]     = op_ss;
  assign cmp_val[C_SE]     = op_se;

  // Bitwise equality: wide AND of per-bit XNOR terms.
  genvar gi;
  generate
    for (gi = 0; gi < NCMP; gi++) begin : g_cmp
      assign match[gi] = &(hcnt_q ~^ cmp_val[gi]);
    end
  endgenerate

  always_comb begin
    hcnt_d      = hcnt_q;
    hsync_d     = hsync_q;
    hblank_d    = hblank_q;
    line_end_d  = 1'b0;
    half_line_d = 1'b0;
    sh_period_d = sh_period_q;
    sh_bb_d     = sh_bb_q;
    sh_be_d     = sh_be_q;
    sh_ss_d     = sh_ss_q;
    sh_se_d     = sh_se_q;

    if (!vid_en) begin
      hcnt_d   = '0;
      hsync_d  = 1'b0;
      hblank_d = 1'b1;
    end else begin
      // Shadows reload only at a line boundary, so mid-line input changes
      // apply from the next line.
      if (first_cyc || match[C_PERIOD]) begin
        hcnt_d      = '0;
        line_end_d  = 1'b1;
        sh_period_d = hperiod;
        sh_bb_d     = hbb;
        sh_be_d     = hbe;
        sh_ss_d     = hss;
        sh_se_d     = hse;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end

      half_line_d = match[C_HALF];

      // Sync: clear beats set on a simultaneous match.
      if (match[C_SE])      hsync_d = 1'b0;
      else if (match[C_SS]) hsync_d = 1'b1;

      // Blank: set beats clear, so equal values blank the whole line.
      if (match[C_BB])      hblank_d = 1'b1;
      else if (match[C_BE]) hblank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      hcnt_q      <= '0;
      hsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      line_end_q  <= 1'b0;
      half_line_q <= 1'b0;
      en_d_q      <= 1'b0;
      sh_period_q <= '0;
      sh_bb_q     <= '0;
      sh_be_q     <= '0;
      sh_ss_q     <= '0;
      sh_se_q     <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      hsync_q     <= hsync_d;
      hblank_q    <= hblank_d;
      line_end_q  <= line_end_d;
      half_line_q <= half_line_d;
      en_d_q      <= vid_en;
      sh_period_q <= sh_period_d;
      sh_bb_q     <= sh_bb_d;
      sh_be_q     <= sh_be_d;
      sh_ss_q     <= sh_ss_d;
      sh_se_q     <= sh_se_d;
    end
  end

  assign hcnt      = hcnt_q;
  assign hsync     = hsync_q;
  assign hblank    = hblank_q;
  assign line_end  = line_end_q;
  assign half_line = half_line_q;

endmodule

// File: tb/tb_vid_htiming.sv
// ---------------------------------------------------------------------------
// tb_vid_htiming -- self-checking bench for vid_htiming.
// A line-level reference model (integer count, modulo line length, shadow
// values captured at line starts) is advanced on every clock edge and
// compared with the DUT one time unit after the edge. A fixed table and
// a few directed sequences cover the specific corner cases.
// ---------------------------------------------------------------------------
module tb_vid_htiming;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         resetl;
  logic         vid_en;
  logic [W-1:0] hperiod, hbb, hbe, hss, hse;
  logic [W-1:0] hcnt;
  logic         hsync, hblank, line_end, half_line;

  int checks = 0;
  int errors = 0;

  vid_htiming #(.W(W)) dut (
    .clk       (clk),
    .resetl    (resetl),
    .vid_en    (vid_en),
    .hperiod   (hperiod),
    .hbb       (hbb),
    .hbe       (hbe),
    .hss       (hss),
    .hse       (hse),
    .hcnt      (hcnt),
    .hsync     (hsync),
    .hblank    (hblank),
    .line_end  (line_end),
    .half_line (half_line)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_cnt, m_per, m_bb, m_be, m_ss, m_se;
  bit m_hs, m_hb, m_le, m_hl, m_en_d;

  task automatic model_reset();
    m_cnt = 0; m_hs = 0; m_hb = 1; m_le = 0; m_hl = 0; m_en_d = 0;
    m_per = 0; m_bb = 0; m_be = 0; m_ss = 0; m_se = 0;
  endtask

  task automatic model_load();
    m_per = int'(hperiod); m_bb = int'(hbb); m_be = int'(hbe);
    m_ss = int'(hss); m_se = int'(hse);
  endtask

  // One pixel clock of the line: a line is m_per+1 counts long; sync and
  // blank are edge events at given positions; half_line marks position
  // floor(period/2).
  task automatic model_edge();
    bit first, at_end;
    int pos;
    if (!vid_en) begin
      m_cnt = 0; m_hs = 0; m_hb = 1; m_le = 0; m_hl = 0; m_en_d = 0;
      return;
    end
    first = !m_en_d;
    m_en_d = 1;
    if (first) model_load();
    pos = m_cnt;
    m_hl = (pos == m_per / 2);
    if (pos == m_se) m_hs = 0; else if (pos == m_ss) m_hs = 1;
    if (pos == m_bb) m_hb = 1; else if (pos == m_be) m_hb = 0;
    at_end = (pos == m_per);
    if (first) begin
      m_cnt = 0; m_le = 1;
    end else begin
      m_cnt = (pos + 1) % (m_per + 1);
      m_le = at_end;
      if (at_end) model_load();
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("hcnt",      int'(hcnt),      m_cnt);
    chk("hsync",     int'(hsync),     int'(m_hs));
    chk("hblank",    int'(hblank),    int'(m_hb));
    chk("line_end",  int'(line_end),  int'(m_le));
    chk("half_line", int'(half_line), int'(m_hl));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  task automatic set_regs(input int p, input int bb, input int be,
                          input int ss, input int se);
    hperiod = W'(p); hbb = W'(bb); hbe = W'(be); hss = W'(ss); hse = W'(se);
  endtask

  // Advance until the model count reaches target (bounded).
  task automatic run_to(input int target, input string name);
    int n;
    n = 0;
    while (m_cnt != target && n < 64) begin
      step();
      n++;
    end
    chk({name, "_reached"}, int'(m_cnt == target), 1);
  endtask

  // Steps until line_end seen (bounded); returns count of steps.
  task automatic steps_to_line_end(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!line_end && n < 64);
  endtask

  typedef struct {
    int hcnt;
    bit hs, hb, le, hl;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n;
    // Expected outputs after each edge following enable with
    // hperiod=9 hss=2 hse=5 hbb=8 hbe=1.
    tbl[0]  = '{0, 0, 1, 1, 0};
    tbl[1]  = '{1, 0, 1, 0, 0};
    tbl[2]  = '{2, 0, 0, 0, 0};
    tbl[3]  = '{3, 1, 0, 0, 0};
    tbl[4]  = '{4, 1, 0, 0, 0};
    tbl[5]  = '{5, 1, 0, 0, 1};
    tbl[6]  = '{6, 0, 0, 0, 0};
    tbl[7]  = '{7, 0, 0, 0, 0};
    tbl[8]  = '{8, 0, 0, 0, 0};
    tbl[9]  = '{9, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 0};
    tbl[11] = '{1, 0, 1, 0, 0};
    tbl[12] = '{2, 0, 0, 0, 0};
    tbl[13] = '{3, 1, 0, 0, 0};

    vid_en = 1'b0;
    set_regs(9, 8, 1, 2, 5);
    resetl = 1'b1;
    #1 resetl = 1'b0;
    #2;
    model_reset();
    $display("phase: reset values");
    cmp_model();
    @(negedge clk);
    resetl = 1'b1;

    // Tests 1/2: table-driven first two lines after enable
    $display("phase: table, hperiod=9");
    vid_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("tbl%0d_hcnt", i),  int'(hcnt),      tbl[i].hcnt);
      chk($sformatf("tbl%0d_hsync", i), int'(hsync),     int'(tbl[i].hs));
      chk($sformatf("tbl%0d_hblank", i), int'(hblank),   int'(tbl[i].hb));
      chk($sformatf("tbl%0d_le", i),    int'(line_end),  int'(tbl[i].le));
      chk($sformatf("tbl%0d_hl", i),    int'(half_line), int'(tbl[i].hl));
    end

    // Test 3: change period mid-line
    $display("phase: period change mid-line");
    run_to(3, "t3_cnt3");
    set_regs(5, 8, 1, 2, 5);
    steps_to_line_end(n);
    chk("t3_old_line_wrap_steps", n, 7);
    steps_to_line_end(n);
    chk("t3_new_line_len", n, 6);
    n = 0;
    while (!half_line && n < 16) begin step(); n++; end
    chk("t3_half_after_cnt2", n, 3);

    // Test 4: equal set/clear values
    $display("phase: equal compare values");
    set_regs(9, 3, 3, 3, 3);
    steps_to_line_end(n);
    for (int i = 0; i < 22; i++) begin
      step();
      chk("t4_hsync_low", int'(hsync), 0);
      if (i > 4) chk("t4_hblank_high", int'(hblank), 1);
    end

    // Test 5: zero period
    $display("phase: hperiod=0");
    set_regs(0, 9, 9, 0, 7);
    steps_to_line_end(n);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_hcnt0", int'(hcnt), 0);
      chk("t5_le", int'(line_end), 1);
      chk("t5_hl", int'(half_line), 1);
      chk("t5_hsync_hold", int'(hsync), 1);
    end

    // Test 6: async reset mid-line with hsync high
    $display("phase: async reset mid-line");
    set_regs(9, 8, 1, 5, 8);
    steps_to_line_end(n);
    run_to(6, "t6_cnt6");
    chk("t6_hsync_pre", int'(hsync), 1);
    #2 resetl = 1'b0;
    #1;
    model_reset();
    chk("t6_async_hcnt", int'(hcnt), 0);
    chk("t6_async_hsync", int'(hsync), 0);
    chk("t6_async_hblank", int'(hblank), 1);
    #1 resetl = 1'b1;
    step();
    chk("t6_hold0", int'(hcnt), 0);
    step();
    chk("t6_count1", int'(hcnt), 1);

    // Test 7: enable drop and re-enable
    $display("phase: enable drop");
    run_to(4, "t7_cnt4");
    vid_en = 1'b0;
    set_regs(7, 6, 2, 1, 3);
    step();
    chk("t7_dis_hcnt", int'(hcnt), 0);
    chk("t7_dis_hblank", int'(hblank), 1);
    chk("t7_dis_hsync", int'(hsync), 0);
    step();
    vid_en = 1'b1;
    step();
    chk("t7_reen_le", int'(line_end), 1);
    steps_to_line_end(n);
    chk("t7_reen_line_len", n, 8);

    // Randomized run against the model
    $display("phase: random");
    for (int i = 0; i < 800; i++) begin
      vid_en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 7) == 0)
        set_regs($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #2 resetl = 1'b0;
        #1 model_reset();
        cmp_model();
        #1 resetl = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vid_htiming.md
Name: vid_htiming

Overview:
- Horizontal video timing generator for the video section.
- 12-bit pixel-clock horizontal counter. Each cycle it compares the count bitwise against shadowed programmed values; every 12-bit equality is a wide AND of per-bit XNOR terms.
- The matches drive registered horizontal sync, horizontal blank, line-end and half-line outputs, which the vertical counter and blank/sync mixing logic downstream consume.

Parameters:
- W, 12, counter and compare width (all values below are W bits)

Ports:
- clk  input  1  video pixel clock
- resetl  input  1  asynchronous active-low reset
- vid_en  input  1  video timing enable
- hperiod  input  W  last count value of a line (line length = hperiod+1)
- hbb  input  W  blank begin count
- hbe  input  W  blank end count
- hss  input  W  sync start count
- hse  input  W  sync end count
- hcnt  output  W  current horizontal count
- hsync  output  1  horizontal sync, active high
- hblank  output  1  horizontal blank, active high
- line_end  output  1  one-cycle pulse, first cycle of a new line
- half_line  output  1  one-cycle pulse at mid-line

Behaviour:
- Clock and reset: one clock, clk. Reset is resetl, asynchronous, active-low.
- Reset values (all flops): hcnt=0, hsync=0, hblank=1, line_end=0, half_line=0, shadow registers=0, en_d=0.
- Shadow registers: sh_period, sh_bb, sh_be, sh_ss, sh_se.
  - Loaded from the inputs on a wrap cycle (vid_en=1 and hcnt==sh_period).
  - Also loaded on the first enabled cycle (vid_en=1, en_d=0).
  - Input changes mid-line take effect from the next line only.
- en_d is vid_en delayed one clock.
- Disabled (vid_en=0): hcnt is forced to 0 on the next edge; hblank=1, hsync=0, line_end=0, half_line=0 (all registered).
- First enabled cycle (vid_en=1, en_d=0):
  - Shadows load; hcnt is held at 0.
  - line_end=1 on the following cycle; this is the start of line 0.
- Normal enabled cycle:
  - If hcnt==sh_period: hcnt<=0 and line_end<=1.
  - Otherwise: hcnt<=hcnt+1 and line_end<=0.
- Wrap arithmetic: modulo 2^W, but the count never passes sh_period because the shadows only change at a wrap.
- sh_period=0: hcnt stays 0; line_end is high every cycle.
- half_line: registered 1 for one cycle after hcnt==(sh_period>>1) is seen. With sh_period=0 it coincides with line_end.
- Compares: all are full W-bit equality of hcnt against the shadows. Every output updates on the edge after the matching count, so there is one cycle of latency.
- hsync:
  - Match with sh_ss sets it (1); match with sh_se clears it (0).
  - Both match in the same cycle: clear wins.
  - No match: hsync holds.
- hblank:
  - Match with sh_bb sets it (1); match with sh_be clears it (0).
  - Both match in the same cycle: set wins, so the line is fully blanked.
  - No match: hblank holds.
- Out-of-range values: a compare value greater than sh_period never matches, so the related output holds its state across lines.
- Simultaneous wrap and compare: a compare at count sh_period acts on the same edge as the wrap.
- Reset mid-line: all outputs return to reset values at once, with no dependence on clk. After release, the first enabled edge follows the first-enabled-cycle rule.
- vid_en dropping mid-line: the next edge forces the disabled state. Shadows keep their values until the next enable.

Test Plan:
1. Reset, then vid_en=1 with hperiod=9:
   - hcnt sequence 0,0,1..9,0,1…
   - line_end high the cycle after enable and the cycle after each hcnt==9.
   - half_line high the cycle after each hcnt==4.
2. hperiod=9, hss=2, hse=5, hbb=8, hbe=1:
   - hsync rises after count 2 and falls after count 5.
   - hblank rises after count 8 and falls after count 1.
   - Pattern repeats every 10 cycles.
3. Change hperiod from 9 to 5 at hcnt=3:
   - The current line still wraps at 9.
   - The next line wraps at 5.
   - half_line moves to after count 2.
4. hss=hse=3:
   - hsync never asserts.
   - With hbb=hbe=3, hblank rises at 3 and stays 1.
5. hperiod=0:
   - hcnt constantly 0.
   - line_end and half_line high every cycle.
   - hse=7 never matches, so hsync holds its value.
6. resetl pulsed low between edges at hcnt=6, hsync=1:
   - hcnt=0, hsync=0, hblank=1 asynchronously.
   - After release with vid_en=1: hcnt holds 0 one cycle, then counts.
7. vid_en dropped at hcnt=4:
   - Next edge gives hcnt=0, hblank=1, hsync=0.
   - Re-enable follows the first-enabled-cycle rule and loads the shadows.
